// File: rtl/intc_pkg.sv
// Shared interrupt-controller definitions: register window geometry and response payload.
package intc_pkg;

  localparam int unsigned INTC_ADDR_W    = 32;
  localparam int unsigned INTC_DATA_W    = 32;
  localparam int unsigned INTC_NUM_ISR   = 4;
  localparam int unsigned INTC_WIN_BYTES = 16;
  localparam int unsigned INTC_SEL_W     = 2;

  localparam logic [INTC_ADDR_W-1:0] INTC_BASE_ADDR = 32'h0002_0000;

  typedef struct packed {
    logic                   err;
    logic [INTC_DATA_W-1:0] data;
  } intc_rsp_t;

  // Response-buffer occupancy, derived from the entry count.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

endpackage

// File: rtl/intc_read_port_if.sv
// Read request/response channel between the bus interconnect and the ISR read port.
interface intc_read_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              rd_rsp_err;

  modport master (
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err
  );

endinterface

// File: rtl/intc_read_address_decoder.sv
// Maps a byte address onto one of the ISR vector registers and flags
// addresses outside the window or not word-aligned.
module intc_read_address_decoder
  import intc_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = ADDR_W'(INTC_BASE_ADDR)
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [INTC_SEL_W-1:0] select_c,
  output logic                  err_c
);

  localparam logic [ADDR_W-1:0] WIN_LAST = BASE_ADDR + ADDR_W'(INTC_WIN_BYTES - 1);

  always_comb begin
    select_c = addr[3:2];
    err_c    = (addr < BASE_ADDR) || (addr > WIN_LAST) || (addr[1:0] != 2'b00);
  end

endmodule

// File: rtl/intc_read_port.sv
// Read-channel front end of the interrupt controller: range-checks requests,
// samples the selected ISR vector register and returns responses in order.
module intc_read_port
  import intc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(INTC_BASE_ADDR),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  intc_read_port_if.slave              bus,
  input  logic [INTC_NUM_ISR*DATA_W-1:0] isr_regs,
  output logic                         rd_busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   WIN_END_EXT = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(INTC_WIN_BYTES - 1);

  // Elaboration-time guards on the parameter set.
  generate
    if (WIN_END_EXT[ADDR_W]) begin : g_win_overflow
      $error("intc_read_port: BASE_ADDR window wraps past the top of the address space");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_bad
      $error("intc_read_port: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (DATA_W != INTC_DATA_W) begin : g_data_w_bad
      $error("intc_read_port: DATA_W must match the response payload width");
    end
  endgenerate

  logic [DATA_W-1:0]     isr_arr [INTC_NUM_ISR];
  logic [INTC_SEL_W-1:0] select_c;
  logic                  addr_err_c;
  intc_rsp_t             rsp_c;

  intc_rsp_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  occ_e                  state_q;
  occ_e                  state_d;
  logic                  push_c;
  logic                  pop_c;

  for (genvar i = 0; i < INTC_NUM_ISR; i++) begin : g_isr_unpack
    assign isr_arr[i] = isr_regs[i*DATA_W +: DATA_W];
  end

  intc_read_address_decoder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_decoder (
    .addr     (bus.rd_req_addr),
    .select_c (select_c),
    .err_c    (addr_err_c)
  );

  // Response captured at acceptance; faulting reads carry zero data.
  always_comb begin
    rsp_c      = '0;
    rsp_c.err  = addr_err_c;
    rsp_c.data = addr_err_c ? '0 : isr_arr[select_c];
  end

  // Handshakes; a pop in the same cycle never re-opens a full buffer.
  always_comb begin
    push_c = bus.rd_req_valid && (state_q != OCC_FULL);
    pop_c  = (state_q != OCC_EMPTY) && bus.rd_rsp_ready;
  end

  // Occupancy register: count, pointers and derived state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)          state_d = OCC_EMPTY;
    else if (count_d == DEPTH_C) state_d = OCC_FULL;
    else                        state_d = OCC_PARTIAL;
  end

  // Outputs decoded from the registered occupancy state and buffer head.
  always_comb begin
    bus.rd_req_ready = 1'b1;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_data  = '0;
    bus.rd_rsp_err   = 1'b0;
    rd_busy          = 1'b0;
    if (state_q == OCC_FULL) bus.rd_req_ready = 1'b0;
    if (state_q != OCC_EMPTY) begin
      bus.rd_rsp_valid = 1'b1;
      bus.rd_rsp_data  = mem_q[rd_ptr_q].data;
      bus.rd_rsp_err   = mem_q[rd_ptr_q].err;
      rd_busy          = 1'b1;
    end
  end

  // Response storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= rsp_c;
    end
  end

endmodule

// File: tb/tb_intc_read_port.sv
// Scoreboard bench for intc_read_port: directed scenarios plus randomized traffic
// checked against an address-window reference model.
module tb_intc_read_port;

  localparam int unsigned    DEPTH = 2;
  localparam logic [31:0]    BASE  = 32'h0002_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  isr [4];
  logic [127:0] isr_regs;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q [$];
  bit          rand_done;

  intc_read_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  intc_read_port #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .isr_regs (isr_regs),
    .rd_busy  (busy)
  );

  assign isr_regs = {isr[3], isr[2], isr[1], isr[0]};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: window is BASE..BASE+15, word-aligned; register index is the word offset.
  function automatic logic [32:0] model_rsp(input logic [31:0] addr);
    longint unsigned a = longint'(addr);
    longint unsigned b = longint'(BASE);
    if (a < b || a >= b + 16 || (a % 4) != 0) return {1'b1, 32'h0};
    return {1'b0, isr[int'((a - b) / 4)]};
  endfunction

  // Monitor/scoreboard: outputs are stable at negedge; handshakes seen here complete at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("rd_busy", 64'(busy), 64'(exp_q.size() != 0));
      chk("rd_rsp_valid", 64'(bus.rd_rsp_valid), 64'(exp_q.size() != 0));
      chk("rd_req_ready", 64'(bus.rd_req_ready), 64'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0) begin
        chk("rsp_data", 64'(bus.rd_rsp_data), 64'(exp_q[0][31:0]));
        chk("rsp_err", 64'(bus.rd_rsp_err), 64'(exp_q[0][32]));
        if (bus.rd_rsp_valid && bus.rd_rsp_ready) void'(exp_q.pop_front());
      end
      if (bus.rd_req_valid && bus.rd_req_ready) exp_q.push_back(model_rsp(bus.rd_req_addr));
    end
  end

  task automatic send(input logic [31:0] a);
    int n = 0;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = a;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rd_req_ready && rst_n) && n < 200);
    if (!bus.rd_req_ready) chk("req_accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.rd_rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return BASE + 32'(4 * $urandom_range(0, 3));
      2:       return BASE - 32'd16 + 32'($urandom_range(0, 47));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_val;
    rst_n            = 1'b0;
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = '0;
    bus.rd_rsp_ready = 1'b1;
    isr[0] = 32'hCAFE_0000;
    isr[1] = 32'hCAFE_0001;
    isr[2] = 32'hCAFE_0002;
    isr[3] = 32'hCAFE_0003;

    #12;
    chk("reset_valid", 64'(bus.rd_rsp_valid), 64'(0));
    chk("reset_ready", 64'(bus.rd_req_ready), 64'(1));
    chk("reset_busy",  64'(busy), 64'(0));
    chk("reset_data",  64'(bus.rd_rsp_data), 64'(0));
    chk("reset_err",   64'(bus.rd_rsp_err), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single in-window read, one-cycle latency.
    send(BASE + 32'h8);
    chk("single_valid", 64'(bus.rd_rsp_valid), 64'(1));
    chk("single_data",  64'(bus.rd_rsp_data), 64'(32'hCAFE_0002));
    chk("single_err",   64'(bus.rd_rsp_err), 64'(0));
    drain();

    // Error cases interleaved with good reads.
    send(BASE + 32'h10);
    send(BASE + 32'h5);
    send(BASE + 32'hC);
    send(BASE - 32'h4);
    send(BASE);
    drain();

    // Backpressure: third request stalls until the consumer resumes.
    bus.rd_rsp_ready = 1'b0;
    send(BASE + 32'h0);
    send(BASE + 32'h4);
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_ready_low", 64'(bus.rd_req_ready), 64'(0));
        chk("bp_head_data", 64'(bus.rd_rsp_data), 64'(32'hCAFE_0000));
        bus.rd_rsp_ready = 1'b1;
      end
    join_none
    send(BASE + 32'hC);
    drain();

    // Streaming: one request per cycle, pointers wrap many times.
    bus.rd_rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(BASE + 32'(4 * (i % 4)));
    drain();

    // Register updated after acceptance: the captured value is returned.
    bus.rd_rsp_ready = 1'b0;
    old_val = isr[1];
    send(BASE + 32'h4);
    isr[1] = 32'h1111_BEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("held_old_value", 64'(bus.rd_rsp_data), 64'(old_val));
    drain();

    // Asynchronous reset with the buffer full.
    bus.rd_rsp_ready = 1'b0;
    send(BASE);
    send(BASE + 32'h8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.rd_rsp_valid), 64'(0));
    chk("midrst_ready", 64'(bus.rd_req_ready), 64'(1));
    chk("midrst_busy",  64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rd_rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with random consumer stalls and register updates.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            send(rand_addr());
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.rd_rsp_ready = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) isr[$urandom_range(0, 3)] = $urandom;
        end
      end
    join
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
